// File: rtl/trigger_surround_cache.sv
// Trigger-surround capture cache: stores ADC samples in a circular buffer, captures
// a window around the first sample above THRESHOLD and shifts it out MSB first.
module trigger_surround_cache #(
    parameter logic [7:0]  THRESHOLD = 8'hD5,
    parameter int unsigned DEPTH     = 32,
    parameter int unsigned PRE       = 16
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        start_i,
    input  logic [7:0]  adc_data_i,
    input  logic        req_i,
    output logic        trd_o,
    output logic        cd_o,
    output logic [31:0] trigtm_o,
    output logic        sd_o
);

    localparam int unsigned AW     = $clog2(DEPTH);
    localparam int unsigned BW     = AW + 3;
    localparam int unsigned POST_N = DEPTH - PRE - 1;
    localparam int unsigned PW     = $clog2(POST_N + 1);

    localparam logic [AW-1:0] PRE_OFS   = AW'(PRE);
    localparam logic [PW-1:0] POST_LAST = PW'(POST_N - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DEPTH * 8 - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_POST  = 2'd2,
        S_SEND  = 2'd3
    } state_t;

    state_t          state_q;
    logic [31:0]     timer_q;
    logic [31:0]     trigtm_q;
    logic [AW-1:0]   wptr_q;
    logic [AW-1:0]   start_idx_q;
    logic [PW-1:0]   post_cnt_q;
    logic [BW-1:0]   bit_cnt_q;
    logic            trd_q;
    logic            cd_q;
    logic            sd_q;
    logic [7:0]      mem_q [DEPTH];

    logic            wr_en_s;
    logic            hit_s;
    logic [BW-1:0]   nxt_bit_s;
    logic [AW-1:0]   rd_addr_s;
    logic [7:0]      rd_byte_s;
    logic            sd_next_s;

    // Write strobe, trigger compare and the serial bit to present on the next edge.
    always_comb begin
        wr_en_s   = 1'b0;
        nxt_bit_s = '0;
        hit_s     = (adc_data_i > THRESHOLD);
        if ((state_q == S_ARMED) || (state_q == S_POST)) begin
            wr_en_s = req_i;
        end else begin
            wr_en_s = 1'b0;
        end
        // Entering SEND presents bit 0; inside SEND the following bit.
        if (state_q == S_SEND) begin
            nxt_bit_s = bit_cnt_q + BW'(1);
        end else begin
            nxt_bit_s = '0;
        end
        rd_addr_s = start_idx_q + nxt_bit_s[BW-1:3];
        rd_byte_s = mem_q[rd_addr_s];
        sd_next_s = rd_byte_s[~nxt_bit_s[2:0]];
    end

    // Free-running event timer.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            timer_q <= 32'd0;
        end else begin
            timer_q <= timer_q + 32'd1;
        end
    end

    // Sample buffer; contents survive re-arming so stale history can be sent.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= 8'h00;
            end
        end else if (wr_en_s) begin
            mem_q[wptr_q] <= adc_data_i;
        end
    end

    // Capture/transmit controller with registered outputs.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= S_IDLE;
            trigtm_q    <= 32'd0;
            wptr_q      <= '0;
            start_idx_q <= '0;
            post_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            trd_q       <= 1'b0;
            cd_q        <= 1'b0;
            sd_q        <= 1'b0;
        end else begin
            cd_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    sd_q <= 1'b0;
                    if (start_i) begin
                        state_q    <= S_ARMED;
                        trd_q      <= 1'b0;
                        wptr_q     <= '0;
                        post_cnt_q <= '0;
                    end
                end
                S_ARMED: begin
                    sd_q <= 1'b0;
                    if (req_i) begin
                        wptr_q <= wptr_q + AW'(1);
                        if (hit_s) begin
                            // Oldest transmitted byte sits PRE entries behind the trigger.
                            start_idx_q <= wptr_q - PRE_OFS;
                            trigtm_q    <= timer_q;
                            trd_q       <= 1'b1;
                            post_cnt_q  <= '0;
                            state_q     <= S_POST;
                        end
                    end
                end
                S_POST: begin
                    sd_q <= 1'b0;
                    if (req_i) begin
                        wptr_q <= wptr_q + AW'(1);
                        if (post_cnt_q == POST_LAST) begin
                            bit_cnt_q <= '0;
                            sd_q      <= sd_next_s;
                            state_q   <= S_SEND;
                        end else begin
                            post_cnt_q <= post_cnt_q + PW'(1);
                        end
                    end
                end
                S_SEND: begin
                    if (bit_cnt_q == BIT_LAST) begin
                        sd_q    <= 1'b0;
                        cd_q    <= 1'b1;
                        state_q <= S_IDLE;
                    end else begin
                        bit_cnt_q <= nxt_bit_s;
                        sd_q      <= sd_next_s;
                    end
                end
                default: begin
                    sd_q    <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign trd_o    = trd_q;
    assign cd_o     = cd_q;
    assign trigtm_o = trigtm_q;
    assign sd_o     = sd_q;

endmodule

// File: tb/tb_trigger_surround_cache.sv
// Scoreboard bench for trigger_surround_cache: a per-edge behavioural model queues
// expected trigger times and 32-byte windows; a negedge monitor checks them.
module tb_trigger_surround_cache;

    localparam int DEPTH = 32;
    localparam int PRE   = 16;
    localparam int NPOST = DEPTH - PRE - 1;
    localparam logic [7:0] TH = 8'hD5;

    logic        clk = 1'b0;
    logic        reset, start, req;
    logic [7:0]  adc;
    logic        trd, cd, sd;
    logic [31:0] trigtm;

    always #5 clk = ~clk;

    trigger_surround_cache dut (
        .clk_i      (clk),
        .reset_i    (reset),
        .start_i    (start),
        .adc_data_i (adc),
        .req_i      (req),
        .trd_o      (trd),
        .cd_o       (cd),
        .trigtm_o   (trigtm),
        .sd_o       (sd)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef enum {M_IDLE, M_ARMED, M_POST, M_SEND} mphase_t;
    mphase_t      ph;
    logic [7:0]   m_mem [DEPTH];
    int           widx, tidx, pcnt, scnt;
    longint       edge_n, last_rst;
    bit           exp_trd, cd_due;
    logic [31:0]  trig_q [$];
    logic [255:0] cap_q  [$];

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // One clock edge: advance the reference model with the inputs seen at the edge,
    // then check the level outputs just after it.
    task automatic tick();
        logic [255:0] s;
        @(posedge clk);
        edge_n++;
        cd_due = 1'b0;
        if (reset) begin
            ph = M_IDLE; widx = 0; pcnt = 0; scnt = 0; exp_trd = 1'b0;
            for (int i = 0; i < DEPTH; i++) m_mem[i] = 8'h00;
            trig_q.delete();
            cap_q.delete();
            last_rst = edge_n;
        end else begin
            case (ph)
                M_IDLE: if (start) begin ph = M_ARMED; widx = 0; exp_trd = 1'b0; end
                M_ARMED: if (req) begin
                    m_mem[widx] = adc;
                    if (adc > TH) begin
                        tidx = widx;
                        trig_q.push_back(32'(edge_n - 1 - last_rst));
                        exp_trd = 1'b1;
                        pcnt = 0;
                        ph = M_POST;
                    end
                    widx = (widx + 1) % DEPTH;
                end
                M_POST: if (req) begin
                    m_mem[widx] = adc;
                    widx = (widx + 1) % DEPTH;
                    pcnt++;
                    if (pcnt == NPOST) begin
                        for (int j = 0; j < DEPTH; j++)
                            s[255 - 8*j -: 8] = m_mem[(tidx + DEPTH - PRE + j) % DEPTH];
                        cap_q.push_back(s);
                        scnt = 0;
                        ph = M_SEND;
                    end
                end
                M_SEND: begin
                    scnt++;
                    if (scnt == DEPTH * 8) begin ph = M_IDLE; cd_due = 1'b1; end
                end
                default: ph = M_IDLE;
            endcase
        end
        #1;
        if (reset) begin
            chk("rst_trd", {31'd0, trd}, 32'd0);
            chk("rst_cd", {31'd0, cd}, 32'd0);
            chk("rst_sd", {31'd0, sd}, 32'd0);
            chk("rst_trigtm", trigtm, 32'd0);
        end else begin
            chk("trd", {31'd0, trd}, {31'd0, exp_trd});
            chk("cd", {31'd0, cd}, {31'd0, cd_due});
            if (ph != M_SEND) chk("sd_idle", {31'd0, sd}, 32'd0);
        end
    endtask

    task automatic idle_ticks(int n);
        req = 1'b0; start = 1'b0;
        repeat (n) tick();
    endtask

    task automatic arm();
        start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic sample(logic [7:0] d);
        req = 1'b1; adc = d; tick(); req = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1; tick(); reset = 1'b0;
    endtask

    // Let a transmission run out, throwing ignored start/req traffic at it.
    task automatic finish_send();
        int k = 0;
        while (ph != M_IDLE && k < 400) begin
            start = 1'($urandom_range(0, 1));
            req   = 1'($urandom_range(0, 1));
            adc   = 8'($urandom);
            tick();
            k++;
        end
        start = 1'b0; req = 1'b0;
        if (ph != M_IDLE) begin
            n_tests++; n_fail++;
            $display("FAIL send_timeout: still sending after %0d clocks", k);
        end
    endtask

    // Monitor: pop expectations whenever the DUT raises trd or pulses cd.
    initial begin
        logic         prev_trd;
        logic [255:0] hist;
        logic [255:0] e;
        prev_trd = 1'b0;
        hist = '0;
        forever begin
            @(negedge clk);
            if (trd === 1'b1 && prev_trd !== 1'b1) begin
                if (trig_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL trd_rise: unexpected trigger, trigtm=%0h", trigtm);
                end else begin
                    chk("trigtm", trigtm, trig_q.pop_front());
                end
            end
            if (cd === 1'b1) begin
                if (cap_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL cd_pulse: unexpected completion at %0t", $time);
                end else begin
                    e = cap_q.pop_front();
                    for (int j = 0; j < DEPTH; j++)
                        chk($sformatf("cap_byte%0d", j), {24'd0, hist[255 - 8*j -: 8]},
                            {24'd0, e[255 - 8*j -: 8]});
                    chk("sd_at_cd", {31'd0, sd}, 32'd0);
                end
            end
            prev_trd = trd;
            hist = {hist[254:0], sd};
        end
    end

    initial begin
        int n;
        edge_n = 0; last_rst = 0; ph = M_IDLE; exp_trd = 1'b0;
        reset = 1'b1; start = 1'b0; req = 1'b0; adc = 8'h00;
        tick();
        reset = 1'b0;
        idle_ticks(1);

        // Arm and trigger on 0xD7, then zeros through the post window.
        arm();
        sample(8'hD7);
        for (int i = 0; i < NPOST; i++) sample(8'h00);
        finish_send();

        // Threshold boundary: 0xD5 must not trigger, 0xD6 must.
        arm();
        sample(8'hD5);
        sample(8'hD6);
        for (int i = 0; i < NPOST; i++) sample(8'(8'h40 + i));
        finish_send();

        // Full capture with a known window.
        arm();
        for (int i = 1; i <= 16; i++) sample(8'(i));
        sample(8'hE0);
        for (int i = 0; i < NPOST; i++) sample(8'(8'h21 + i));
        finish_send();
        idle_ticks(2);

        // Early trigger after reset: pre-history is zero.
        do_reset();
        arm();
        sample(8'hFF);
        for (int i = 0; i < NPOST; i++) sample(8'(8'hA0 + i));
        finish_send();

        // Reset 100 clocks into a transmission, then re-arm.
        arm();
        for (int i = 0; i < 20; i++) sample(8'(8'h50 + i));
        sample(8'hF0);
        for (int i = 0; i < NPOST; i++) sample(8'(8'h60 + i));
        idle_ticks(100);
        do_reset();
        idle_ticks(5);
        arm();
        for (int i = 1; i <= 16; i++) sample(8'(i));
        sample(8'hE0);
        for (int i = 0; i < NPOST; i++) sample(8'(8'h21 + i));
        finish_send();

        // Randomised captures with req gaps and stray starts.
        for (int it = 0; it < 8; it++) begin
            idle_ticks($urandom_range(0, 3));
            arm();
            n = $urandom_range(0, 45);
            for (int i = 0; i < n; i++) begin
                req   = 1'($urandom_range(0, 3) != 0);
                start = 1'($urandom_range(0, 1));
                adc   = 8'($urandom_range(0, 32'hD5));
                tick();
            end
            start = 1'b0;
            while (ph == M_ARMED) sample(8'($urandom_range(32'hD6, 32'hFF)));
            n = 0;
            while (ph == M_POST && n < 200) begin
                req = 1'($urandom_range(0, 3) != 0);
                adc = 8'($urandom);
                tick();
                n++;
            end
            req = 1'b0;
            finish_send();
        end

        idle_ticks(3);
        chk("trig_q_drained", 32'(trig_q.size()), 32'd0);
        chk("cap_q_drained", 32'(cap_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/trigger_surround_cache.md
# trigger_surround_cache

Trigger-surround capture cache between the ADC sample stream and a serial readout link. Once armed by `start`, it continuously stores 8-bit ADC samples in a 32-entry circular buffer and waits for a sample above a threshold. On that trigger it time-stamps the event and captures a fixed window of post-trigger samples. It then shifts the whole 32-sample window (pre-trigger, trigger and post-trigger) out on a one-bit serial line.

## Interface
- `THRESHOLD`, 8'hD5: trigger level; the trigger condition is `adc_data > THRESHOLD` (unsigned, strict).
- `DEPTH`, 32: buffer entries and samples transmitted per capture.
- `PRE`, 16: samples transmitted before the trigger sample; `DEPTH-PRE-1` (15) samples are captured after it.

- `clk` in 1: single clock; all logic on rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: arm request, sampled only in IDLE.
- `adc_data` in 8: ADC sample, valid when `req`=1.
- `req` in 1: sample strobe; one sample accepted per clock with `req`=1.
- `trd` out 1: trigger detected (level).
- `cd` out 1: capture/transfer complete, one-cycle pulse.
- `trigtm` out 32: timer value at trigger.
- `sd` out 1: serial data out.

## Operation
- Free-running 32-bit timer: 0 after reset, +1 every clock, wraps 2^32-1 to 0.
- States: IDLE, ARMED, POST, SEND.
- IDLE:
  - `start`=1 -> ARMED.
  - On this transition: `trd` cleared, write pointer and post counter cleared, buffer contents kept.
- ARMED:
  - Each `req`=1 cycle writes `adc_data` at the write pointer; pointer advances mod `DEPTH`.
  - If the written sample is > `THRESHOLD`:
    - record its buffer index as trigger index;
    - `trigtm` <= timer;
    - `trd` <= 1;
    - -> POST.
- POST:
  - Each `req`=1 cycle writes one sample; after the 15th post-trigger sample -> SEND.
  - Threshold is not re-evaluated.
- SEND:
  - Transmits `DEPTH` bytes, oldest first, starting at index (trigger index − `PRE`) mod `DEPTH`.
  - Each byte MSB first, one bit per clock, 256 clocks total.
  - `req`/`adc_data` ignored.
  - After the last bit: `cd`=1 for one cycle, -> IDLE.
- `start` is ignored outside IDLE. `trd` and `trigtm` hold until the next arming or reset.
- Buffer is cleared to 8'h00 on reset. Missing pre-trigger history (trigger before 16 samples stored) is therefore transmitted as zero bytes or stale data from an earlier capture.
- Reset at any time, including mid-SEND:
  - state IDLE, `sd`=0, `cd`=0, `trd`=0, `trigtm`=0, timer=0, buffer=0, pointers=0.

## Timing
- Reset values: `trd`=0, `cd`=0, `trigtm`=0, `sd`=0.
- `start` high at edge N in IDLE -> ARMED from edge N; a sample with `req`=1 at edge N+1 is the first stored.
- Trigger sample at edge T:
  - `trd`=1 after edge T;
  - `trigtm` = timer value before edge T, stable after edge T.
- 15th post sample at edge P: SEND from edge P; first bit (MSB of oldest byte) on `sd` after edge P.
- Bit k (0..255) valid after edge P+k.
- `cd` high after edge P+256 for exactly one cycle.
- `sd`=0 whenever not in SEND.
- Sample accept-to-store latency: 1 clock. `req`=0 cycles store nothing and do not advance counters.

## Test plan
- Reset: `reset`=1 for 1 clock -> `trd`=0, `cd`=0, `trigtm`=0, `sd`=0.
- Arm and trigger: `start`=1 at 30 ns, then `req`=1 with 8'hD7 -> `trd`=1 next cycle; `trigtm` equals the cycle count at that edge. Follow with 8'h00 -> no state change beyond POST.
- Threshold boundary: `adc_data`=8'hD5 with `req`=1 -> no trigger; 8'hD6 -> trigger.
- Full capture: arm, feed 16 samples 0x01..0x10, trigger 0xE0, then 15 samples 0x21..0x2F -> `sd` emits 0x01..0x10, 0xE0, 0x21..0x2F MSB-first over 256 clocks; `cd` pulses once; returns to IDLE.
- Early trigger: arm after reset, first sample 0xFF -> transmitted stream starts with 16 zero bytes, then 0xFF.
- Reset mid-SEND: assert `reset` 100 clocks into SEND -> all outputs 0 next cycle, no `cd`; a new `start` re-arms normally.
